// File: rtl/card_click_resolver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : card_click_resolver_pkg
// Description : Shared card macros: field widths, card pixel size, card
//               state encoding and the click-resolver state type.
// Revision    : 1.0 - initial release
// ============================================================================
package card_click_resolver_pkg;

    localparam int CARD_ADDRESS_SIZE     = 5;
    localparam int CARD_MAX_NUM_SIZE     = 6;
    localparam int CARD_YX_POSITION_SIZE = 20;
    localparam int CARD_STATE_SIZE       = 2;
    localparam int CARD_DATA_SIZE        = 14;
    localparam int CARD_WIDTH            = 64;
    localparam int CARD_HEIGHT           = 64;

    // Card state code for a face-down card
    localparam int STATE_HIDDEN          = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_READ  = 2'd2,
        S_CHECK = 2'd3
    } resolver_state_t;

endpackage
`default_nettype wire

// File: rtl/card_pos_table.sv
`default_nettype none
// ============================================================================
// Module      : card_pos_table
// Description : Card position table, one synchronous write port and one
//               combinational read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module card_pos_table #(
    parameter int ADDR_W = 5,
    parameter int POS_W  = 20
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [POS_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [POS_W-1:0]  rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [POS_W-1:0] r_mem [DEPTH];

    // Store the streamed position of one card
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/card_click_resolver.sv
`default_nettype none
// ============================================================================
// Module      : card_click_resolver
// Description : Captures the card broadcast stream into a position table,
//               maps a mouse click onto a card, reads its state back from
//               the core and pulses card_pressed for a face-down hit.
// Revision    : 1.0 - initial release
// ============================================================================
module card_click_resolver
    import card_click_resolver_pkg::*;
#(
    parameter int ADDR_W  = CARD_ADDRESS_SIZE,
    parameter int NUM_W   = CARD_MAX_NUM_SIZE,
    parameter int COORD_W = CARD_YX_POSITION_SIZE / 2,
    parameter int STATE_W = CARD_STATE_SIZE,
    parameter int DATA_W  = CARD_DATA_SIZE,
    parameter int CARD_W  = CARD_WIDTH,
    parameter int CARD_H  = CARD_HEIGHT,
    parameter int RD_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_W-1:0]     num_of_cards,
    input  logic                 wait_for_click_en,
    input  logic                 stream_valid,
    input  logic [2*COORD_W-1:0] stream_yx,
    input  logic                 click,
    input  logic [COORD_W-1:0]   click_x,
    input  logic [COORD_W-1:0]   click_y,
    input  logic [DATA_W-1:0]    card_data,
    output logic [ADDR_W-1:0]    card_to_test_address,
    output logic [ADDR_W-1:0]    card_clicked_address,
    output logic                 card_pressed,
    output logic                 busy
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int SUM_W = COORD_W + 1;
    localparam int CMP_W = ((NUM_W > ADDR_W) ? NUM_W : ADDR_W) + 1;

    resolver_state_t      r_state, w_state_nxt;
    logic [ADDR_W:0]      r_wr_idx;
    logic                 w_wr_en;
    logic [ADDR_W-1:0]    r_idx, w_idx_nxt;
    logic [COORD_W-1:0]   r_x, w_x_nxt, r_y, w_y_nxt;
    logic [ADDR_W-1:0]    r_test_addr, w_test_addr_nxt;
    logic [ADDR_W-1:0]    r_clicked_addr, w_clicked_addr_nxt;
    logic [LAT_W-1:0]     r_lat_cnt, w_lat_cnt_nxt;
    logic [2*COORD_W-1:0] w_entry;
    logic [COORD_W-1:0]   w_cx, w_cy;
    logic                 w_hit, w_last, w_abort, w_pressed;
    logic                 w_unused_data;

    // Write index: counts stream cycles, parks at DEPTH so overflow is dropped
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_idx <= '0;
        end else if (!stream_valid) begin
            r_wr_idx <= '0;
        end else if (!r_wr_idx[ADDR_W]) begin
            r_wr_idx <= r_wr_idx + 1'b1;
        end
    end

    assign w_wr_en = stream_valid && !r_wr_idx[ADDR_W];

    card_pos_table #(
        .ADDR_W (ADDR_W),
        .POS_W  (2*COORD_W)
    ) u_card_pos_table (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (r_wr_idx[ADDR_W-1:0]),
        .wr_data (stream_yx),
        .rd_addr (r_idx),
        .rd_data (w_entry)
    );

    // Hit test at COORD_W+1 bits so cx+CARD_W cannot wrap
    assign w_cx  = w_entry[COORD_W-1:0];
    assign w_cy  = w_entry[2*COORD_W-1:COORD_W];
    assign w_hit = (r_x >= w_cx) && (SUM_W'(r_x) < SUM_W'(w_cx) + SUM_W'(CARD_W)) &&
                   (r_y >= w_cy) && (SUM_W'(r_y) < SUM_W'(w_cy) + SUM_W'(CARD_H));

    // Last entry is num_of_cards-1, or the table end if more cards are claimed
    assign w_last  = (CMP_W'(r_idx) + 1'b1 >= CMP_W'(num_of_cards)) || (&r_idx);
    assign w_abort = stream_valid || !wait_for_click_en;
    assign w_unused_data = ^card_data[DATA_W-1:STATE_W];

    // Next-state, datapath and pulse decode
    always_comb begin
        w_state_nxt        = r_state;
        w_idx_nxt          = r_idx;
        w_x_nxt            = r_x;
        w_y_nxt            = r_y;
        w_test_addr_nxt    = r_test_addr;
        w_clicked_addr_nxt = r_clicked_addr;
        w_lat_cnt_nxt      = r_lat_cnt;
        w_pressed          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (click && wait_for_click_en && !stream_valid) begin
                    w_x_nxt     = click_x;
                    w_y_nxt     = click_y;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_abort || (num_of_cards == '0)) begin
                    w_state_nxt = S_IDLE;
                end else if (w_hit) begin
                    w_test_addr_nxt = r_idx;
                    w_lat_cnt_nxt   = '0;
                    w_state_nxt     = S_READ;
                end else if (w_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_READ: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_lat_cnt == LAT_W'(RD_LAT - 1)) begin
                    w_state_nxt = S_CHECK;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt + 1'b1;
                end
            end
            S_CHECK: begin
                w_state_nxt = S_IDLE;
                if (!w_abort && (card_data[STATE_W-1:0] == STATE_W'(STATE_HIDDEN))) begin
                    w_pressed          = 1'b1;
                    w_clicked_addr_nxt = r_test_addr;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_x            <= '0;
            r_y            <= '0;
            r_test_addr    <= '0;
            r_clicked_addr <= '0;
            r_lat_cnt      <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_idx          <= w_idx_nxt;
            r_x            <= w_x_nxt;
            r_y            <= w_y_nxt;
            r_test_addr    <= w_test_addr_nxt;
            r_clicked_addr <= w_clicked_addr_nxt;
            r_lat_cnt      <= w_lat_cnt_nxt;
        end
    end

    // Accepted address is visible in the pulse cycle and held afterwards
    assign card_pressed         = w_pressed;
    assign card_clicked_address = w_pressed ? r_test_addr : r_clicked_addr;
    assign card_to_test_address = r_test_addr;
    assign busy                 = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_card_click_resolver.sv
`default_nettype none
// ============================================================================
// Module      : tb_card_click_resolver
// Description : Directed self-checking bench for card_click_resolver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_card_click_resolver;

    logic        clk;
    logic        rst;
    logic [5:0]  num_of_cards;
    logic        wait_for_click_en;
    logic        stream_valid;
    logic [19:0] stream_yx;
    logic        click;
    logic [9:0]  click_x;
    logic [9:0]  click_y;
    logic [13:0] card_data;
    logic [4:0]  card_to_test_address;
    logic [4:0]  card_clicked_address;
    logic        card_pressed;
    logic        busy;

    logic [13:0] card_state_mem [32];
    logic [19:0] tb_pos [64];
    int          tests_run;
    int          tests_failed;

    card_click_resolver dut (
        .clk                  (clk),
        .rst                  (rst),
        .num_of_cards         (num_of_cards),
        .wait_for_click_en    (wait_for_click_en),
        .stream_valid         (stream_valid),
        .stream_yx            (stream_yx),
        .click                (click),
        .click_x              (click_x),
        .click_y              (click_y),
        .card_data            (card_data),
        .card_to_test_address (card_to_test_address),
        .card_clicked_address (card_clicked_address),
        .card_pressed         (card_pressed),
        .busy                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core register-file read port model, one cycle latency
    always @(posedge clk) card_data <= card_state_mem[card_to_test_address];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic stream_cards(input int n);
        for (int i = 0; i < n; i++) begin
            stream_valid = 1'b1;
            stream_yx    = tb_pos[i];
            tick();
        end
        stream_valid = 1'b0;
        tick();
    endtask

    // Click at cycle t, then observe cycles t+1..t+budget
    task automatic do_click(input logic [9:0] x, input logic [9:0] y, input int budget,
                            output int pulse_at, output logic [4:0] pulse_addr,
                            output int n_pulse, output int idle_at);
        click   = 1'b1;
        click_x = x;
        click_y = y;
        tick();
        click      = 1'b0;
        pulse_at   = -1;
        idle_at    = -1;
        n_pulse    = 0;
        pulse_addr = '0;
        for (int c = 1; c <= budget; c++) begin
            if (card_pressed) begin
                n_pulse++;
                if (pulse_at < 0) begin
                    pulse_at   = c;
                    pulse_addr = card_clicked_address;
                end
            end
            if (!busy && idle_at < 0) idle_at = c;
            tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick();
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_busy got %b want 0", busy);
        end
        tests_run++;
        if (card_pressed !== 1'b0) begin
            tests_failed++; $display("FAIL reset_pressed got %b want 0", card_pressed);
        end
        tests_run++;
        if (card_clicked_address !== 5'd0) begin
            tests_failed++; $display("FAIL reset_clicked_addr got %0d want 0", card_clicked_address);
        end
        tests_run++;
        if (card_to_test_address !== 5'd0) begin
            tests_failed++; $display("FAIL reset_test_addr got %0d want 0", card_to_test_address);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_hit;
        int p, n, idl;
        logic [4:0] a;
        for (int i = 0; i < 4; i++) tb_pos[i] = {10'd0, 10'(i * 80)};
        stream_cards(4);
        num_of_cards      = 6'd4;
        wait_for_click_en = 1'b1;
        card_state_mem[2] = 14'h0;
        do_click(10'd170, 10'd10, 10, p, a, n, idl);
        tests_run++;
        if (p !== 5) begin
            tests_failed++; $display("FAIL hit_pulse_cycle got %0d want 5", p);
        end
        tests_run++;
        if (a !== 5'd2) begin
            tests_failed++; $display("FAIL hit_addr got %0d want 2", a);
        end
        tests_run++;
        if (n !== 1) begin
            tests_failed++; $display("FAIL hit_pulse_count got %0d want 1", n);
        end
        tests_run++;
        if (idl !== 6) begin
            tests_failed++; $display("FAIL hit_idle_cycle got %0d want 6", idl);
        end
        tests_run++;
        if (card_to_test_address !== 5'd2) begin
            tests_failed++; $display("FAIL hit_test_addr got %0d want 2", card_to_test_address);
        end
    endtask

    task automatic test_face_up;
        int p, n, idl;
        logic [4:0] a;
        card_state_mem[3] = 14'h1;
        do_click(10'd270, 10'd10, 10, p, a, n, idl);
        tests_run++;
        if (n !== 0) begin
            tests_failed++; $display("FAIL faceup_pulses got %0d want 0", n);
        end
        tests_run++;
        if (idl !== 7) begin
            tests_failed++; $display("FAIL faceup_idle_cycle got %0d want 7", idl);
        end
    endtask

    task automatic test_gap_miss;
        int p, n, idl;
        logic [4:0] a;
        do_click(10'd70, 10'd10, 8, p, a, n, idl);
        tests_run++;
        if (n !== 0) begin
            tests_failed++; $display("FAIL gap_pulses got %0d want 0", n);
        end
        tests_run++;
        if (idl !== 5) begin
            tests_failed++; $display("FAIL gap_idle_cycle got %0d want 5", idl);
        end
        tests_run++;
        if (card_clicked_address !== 5'd2) begin
            tests_failed++; $display("FAIL gap_addr_hold got %0d want 2", card_clicked_address);
        end
    endtask

    task automatic test_zero_cards;
        int p, n, idl;
        logic [4:0] a;
        num_of_cards = 6'd0;
        do_click(10'd10, 10'd10, 6, p, a, n, idl);
        tests_run++;
        if (idl !== 2 || n !== 0) begin
            tests_failed++; $display("FAIL zero_cards idle %0d pulses %0d want 2 0", idl, n);
        end
        num_of_cards = 6'd4;
    endtask

    task automatic test_ignored_clicks;
        int p, n;
        logic [4:0] a;
        wait_for_click_en = 1'b0;
        click = 1'b1; click_x = 10'd170; click_y = 10'd10;
        tick();
        click = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++; $display("FAIL disabled_click busy got %b want 0", busy);
        end
        tick();
        wait_for_click_en = 1'b1;
        card_state_mem[0] = 14'h0;
        card_state_mem[3] = 14'h0;
        click = 1'b1; click_x = 10'd250; click_y = 10'd20;
        tick();
        click_x = 10'd5; click_y = 10'd5;
        p = -1; n = 0; a = '0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 2) click = 1'b0;
            if (card_pressed) begin
                n++;
                if (p < 0) begin p = c; a = card_clicked_address; end
            end
            tick();
        end
        click = 1'b0;
        tests_run++;
        if (p !== 6 || a !== 5'd3 || n !== 1) begin
            tests_failed++; $display("FAIL busy_click cycle %0d addr %0d pulses %0d want 6 3 1", p, a, n);
        end
    endtask

    task automatic test_abort_and_restream;
        int p, n, idl;
        logic [4:0] a;
        card_state_mem[3] = 14'h0;
        click = 1'b1; click_x = 10'd250; click_y = 10'd20;
        tick();
        click = 1'b0;
        tick();
        tb_pos[0] = {10'd0, 10'd500};
        tb_pos[1] = {10'd0, 10'd600};
        stream_valid = 1'b1; stream_yx = tb_pos[0];
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++; $display("FAIL abort_busy got %b want 0", busy);
        end
        stream_yx = tb_pos[1];
        tick();
        stream_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (card_pressed) n++;
            tick();
        end
        tests_run++;
        if (n !== 0) begin
            tests_failed++; $display("FAIL abort_pulses got %0d want 0", n);
        end
        num_of_cards = 6'd2;
        do_click(10'd510, 10'd10, 6, p, a, n, idl);
        tests_run++;
        if (p !== 3 || a !== 5'd0) begin
            tests_failed++; $display("FAIL restream_hit cycle %0d addr %0d want 3 0", p, a);
        end
        do_click(10'd5, 10'd5, 6, p, a, n, idl);
        tests_run++;
        if (n !== 0 || idl !== 3) begin
            tests_failed++; $display("FAIL restream_old_pos pulses %0d idle %0d want 0 3", n, idl);
        end
    endtask

    task automatic test_overflow;
        int p, n, idl;
        logic [4:0] a;
        for (int i = 0; i < 32; i++) tb_pos[i] = {10'((i / 8) * 70), 10'((i % 8) * 70)};
        for (int i = 32; i < 40; i++) tb_pos[i] = {10'd400, 10'((i - 32) * 70)};
        stream_cards(40);
        num_of_cards       = 6'd32;
        card_state_mem[31] = 14'h0;
        card_state_mem[0]  = 14'h0;
        do_click(10'd495, 10'd215, 40, p, a, n, idl);
        tests_run++;
        if (p !== 34 || a !== 5'd31) begin
            tests_failed++; $display("FAIL overflow_last cycle %0d addr %0d want 34 31", p, a);
        end
        do_click(10'd5, 10'd5, 6, p, a, n, idl);
        tests_run++;
        if (p !== 3 || a !== 5'd0) begin
            tests_failed++; $display("FAIL overflow_no_wrap cycle %0d addr %0d want 3 0", p, a);
        end
    endtask

    task automatic test_mid_reset;
        card_state_mem[3] = 14'h0;
        num_of_cards = 6'd32;
        click = 1'b1; click_x = 10'd215; click_y = 10'd5;
        tick();
        click = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b0 || card_pressed !== 1'b0) begin
            tests_failed++; $display("FAIL mid_reset busy %b pressed %b want 0 0", busy, card_pressed);
        end
        rst = 1'b1;
        tests_run++;
        if (card_clicked_address !== 5'd0) begin
            tests_failed++; $display("FAIL mid_reset_addr got %0d want 0", card_clicked_address);
        end
    endtask

    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        rst               = 1'b0;
        num_of_cards      = '0;
        wait_for_click_en = 1'b0;
        stream_valid      = 1'b0;
        stream_yx         = '0;
        click             = 1'b0;
        click_x           = '0;
        click_y           = '0;
        for (int i = 0; i < 32; i++) card_state_mem[i] = 14'h1;
        test_reset();
        test_hit();
        test_face_up();
        test_gap_miss();
        test_zero_cards();
        test_ignored_clicks();
        test_abort_and_restream();
        test_overflow();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
